// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable 32-bit word memory, IDLE/RUN/HALT sequencer, registered NOP-padded issue.
// Optional retired-instruction counter port enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              stall,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
`ifdef IFU_PERF_CNT_EN
  output logic              done,
  output logic [15:0]       retired_cnt
`else
  output logic              done
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [31:0]       SENTINEL = 32'hFFFF_FFFF;
  localparam logic [31:0]       NOP      = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       fetch_word;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  assign fetch_word = mem_q[pc_q];

  // NOTE: the memory has no reset so a program survives rst_n; a reset loop here would also block RAM inference.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == IDLE) && load_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
`ifdef IFU_PERF_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef IFU_PERF_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = NOP;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (fetch_word == SENTINEL) begin
            state_d = HALT;
          end else begin
            instr_d = fetch_word;
            valid_d = 1'b1;
            // The last word is issued and then execution stops rather than running off the end.
            if (pc_q == LAST_PC) begin
              pc_d    = '0;
              state_d = HALT;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

`ifdef IFU_PERF_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != RUN) && start) begin
      cnt_d = '0;
    end else if (valid_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
`endif

  always_comb begin
    instruction = instr_q;
    instr_valid = valid_q;
    pc          = pc_q;
    busy        = (state_q == RUN);
    done        = (state_q == HALT);
`ifdef IFU_PERF_CNT_EN
    retired_cnt = cnt_q;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of expected post-edge outputs, checked by immediate assertions.
module tb_instr_fetch_unit;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  localparam logic [31:0] W_ADD  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] W_SUB  = 32'h0022_2022; // sub $4,$1,$2
  localparam logic [31:0] W_SLT  = 32'h0022_282A; // slt $5,$1,$2
  localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W_NEW  = 32'h0062_2020; // add $4,$3,$2
  localparam logic [31:0] W_JUNK = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              stall;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]       retired_cnt;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
`ifdef IFU_PERF_CNT_EN
    .done        (done),
    .retired_cnt (retired_cnt)
`else
    .done        (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the outputs expected after the next edge, clock it, then pop and compare.
  task automatic step(input string tag, input logic [31:0] instr, input logic valid,
                      input logic [3:0] exp_pc, input logic exp_busy, input logic exp_done);
    exp_t e;
    sb.push_back('{tag, instr, valid, exp_pc, exp_busy, exp_done});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".instr"}, instruction, e.instr);
    check({e.tag, ".valid"}, 32'(instr_valid), 32'(e.valid));
    check({e.tag, ".pc"},    32'(pc),          32'(e.pc));
    check({e.tag, ".busy"},  32'(busy),        32'(e.busy));
    check({e.tag, ".done"},  32'(done),        32'(e.done));
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    step("load", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    load_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill [DEPTH];
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; stall = 1'b0;
    step("reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Three-instruction program ending in the halt sentinel.
    load(4'd0, W_ADD);
    load(4'd1, W_SUB);
    load(4'd2, W_SLT);
    load(4'd3, W_HALT);
    start = 1'b1;
    step("start", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    step("p_issue0", W_ADD, 1'b1, 4'd1, 1'b1, 1'b0);
    step("p_issue1", W_SUB, 1'b1, 4'd2, 1'b1, 1'b0);
    step("p_issue2", W_SLT, 1'b1, 4'd3, 1'b1, 1'b0);
    step("p_sentinel", 32'h0, 1'b0, 4'd3, 1'b0, 1'b1);
`ifdef IFU_PERF_CNT_EN
    check("cnt_at_halt", 32'(retired_cnt), 32'd3);
`endif
    step("p_halt_hold", 32'h0, 1'b0, 4'd3, 1'b0, 1'b1);

    // Restart from HALT, stall two cycles after the first issue; load_we and start in RUN are ignored.
    start = 1'b1;
    step("s_restart", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef IFU_PERF_CNT_EN
    check("cnt_after_restart", 32'(retired_cnt), 32'd0);
`endif
    start = 1'b0;
    step("s_issue0", W_ADD, 1'b1, 4'd1, 1'b1, 1'b0);
    stall = 1'b1;
    load_we = 1'b1; load_addr = 4'd1; load_data = W_JUNK;
    step("s_stall1", 32'h0, 1'b0, 4'd1, 1'b1, 1'b0);
    load_we = 1'b0;
    step("s_stall2", 32'h0, 1'b0, 4'd1, 1'b1, 1'b0);
    stall = 1'b0;
    step("s_issue1", W_SUB, 1'b1, 4'd2, 1'b1, 1'b0);
    start = 1'b1;
    step("s_issue2", W_SLT, 1'b1, 4'd3, 1'b1, 1'b0);
    start = 1'b0;
    step("s_sentinel", 32'h0, 1'b0, 4'd3, 1'b0, 1'b1);

    // Reset mid-RUN (with start and load_we asserted) must not disturb memory.
    start = 1'b1;
    step("r_restart", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    step("r_issue0", W_ADD, 1'b1, 4'd1, 1'b1, 1'b0);
    step("r_issue1", W_SUB, 1'b1, 4'd2, 1'b1, 1'b0);
    rst_n = 1'b0; start = 1'b1; stall = 1'b1;
    load_we = 1'b1; load_addr = 4'd0; load_data = W_JUNK;
    step("r_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
    check("cnt_after_reset", 32'(retired_cnt), 32'd0);
`endif
    rst_n = 1'b1; load_we = 1'b0; stall = 1'b0;
    step("r_start", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    step("r_rerun0", W_ADD, 1'b1, 4'd1, 1'b1, 1'b0);
    step("r_rerun1", W_SUB, 1'b1, 4'd2, 1'b1, 1'b0);
    step("r_rerun2", W_SLT, 1'b1, 4'd3, 1'b1, 1'b0);
    step("r_sentinel", 32'h0, 1'b0, 4'd3, 1'b0, 1'b1);

    // Write and start in the same IDLE cycle: the first fetch sees the new word.
    rst_n = 1'b0;
    step("w_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    load_we = 1'b1; load_addr = 4'd0; load_data = W_NEW; start = 1'b1;
    step("w_load_start", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    load_we = 1'b0; start = 1'b0;
    step("w_issue0", W_NEW, 1'b1, 4'd1, 1'b1, 1'b0);
    step("w_issue1", W_SUB, 1'b1, 4'd2, 1'b1, 1'b0);
    step("w_issue2", W_SLT, 1'b1, 4'd3, 1'b1, 1'b0);
    step("w_sentinel", 32'h0, 1'b0, 4'd3, 1'b0, 1'b1);

    // Full memory with no sentinel: 16 issues, pc wraps to 0, HALT.
    rst_n = 1'b0;
    step("f_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 32'h1000_0000 | ($urandom & 32'h00FF_FFFF) | 32'(i);
      load(4'(i), fill[i]);
    end
    start = 1'b1;
    step("f_start", 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) step($sformatf("f_issue%0d", i), fill[i], 1'b1, 4'd0, 1'b0, 1'b1);
      else                step($sformatf("f_issue%0d", i), fill[i], 1'b1, 4'(i + 1), 1'b1, 1'b0);
    end
    step("f_after_wrap", 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
`ifdef IFU_PERF_CNT_EN
    check("cnt_full", 32'(retired_cnt), 32'd16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
